eeprom_i2c_seq: RTL and testbench
=================================

Name: eeprom_i2c_seq

Overview:
- Transaction sequencer directly upstream of the byte-level I2C master in the memory subsystem.
- Converts host requests (write or random-read N bytes at an 8-bit word address of a 24Cxx-style EEPROM) into a stream of byte commands for the I2C master: START, device address, word address, data, repeated START and STOP.
- Splits writes at EEPROM page boundaries and enforces the internal write-cycle time.

Parameters:
- LEN_W, 4, width of req_len; a request carries 1..2^LEN_W bytes.
- PAGE_SIZE, 8, EEPROM page size in bytes; power of two, at most 256.
- WR_WAIT_CYCLES, 500000, clk cycles to wait after each page-write STOP.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  host request valid
- req_ready  out  1  sequencer idle, accepts a request
- req_rw  in  1  0 = write, 1 = read
- req_dev  in  7  7-bit device address
- req_waddr  in  8  starting word address
- req_len  in  LEN_W  byte count minus 1
- wr_data  in  8  write byte from host
- wr_valid  in  1  write byte valid
- wr_ready  out  1  sequencer takes wr_data this cycle
- rd_data  out  8  read byte
- rd_valid  out  1  one-cycle pulse per read byte; no backpressure
- done  out  1  one-cycle pulse at the end of a successful request
- err  out  1  one-cycle pulse at the end of a NACK-aborted request
- cmd_valid  out  1  byte command valid to the I2C master
- cmd_ready  in  1  I2C master accepts the command
- cmd_start  out  1  precede the byte with START or repeated START
- cmd_stop  out  1  follow the byte with STOP
- cmd_read  out  1  read a byte; cmd_wdata is ignored
- cmd_ack  out  1  for reads: master drives ACK (1) or NACK (0)
- cmd_wdata  out  8  byte to transmit
- rsp_valid  in  1  command completed
- rsp_rdata  in  8  received byte
- rsp_nack  in  1  slave NACKed a transmitted byte

Behaviour:
- Reset: reset is rst_n, asynchronous, active-low; clock is clk. Every output resets to 0 except req_ready, which resets to 1. Registers return to IDLE.
- Reset mid-operation aborts the transaction with no STOP issued. The I2C master shares rst_n.
- Request handshake: a request is accepted on req_valid & req_ready. req_ready is high only in IDLE. The sequencer latches dev, waddr, remaining = req_len + 1 and rw.
- Command handshake:
  - At most one command is outstanding.
  - cmd_valid and every cmd_* field stay stable until cmd_ready.
  - After acceptance the sequencer waits for rsp_valid before issuing the next command.
- States and transitions:
  - IDLE -> DEV_W on accept.
  - DEV_W: start=1, wdata={dev,0}. If rsp_nack -> ABORT, else -> WADDR.
  - WADDR: wdata=waddr. If rsp_nack -> ABORT. Otherwise -> WDATA (write) or DEV_R (read).
  - WDATA:
    - wr_ready pulses one cycle when wr_valid is high and no command is pending. The byte is loaded into cmd_wdata.
    - cmd_stop=1 when remaining==1 or (waddr+1) mod PAGE_SIZE == 0.
    - On rsp: rsp_nack -> ABORT. Otherwise decrement remaining and increment waddr mod 256.
    - If stop was sent: -> WAIT.
  - WAIT: count WR_WAIT_CYCLES. Then, if remaining==0 -> DONE, else -> DEV_W with the updated waddr.
  - DEV_R: start=1 (repeated START), wdata={dev,1}. If rsp_nack -> ABORT, else -> RDATA.
  - RDATA:
    - cmd_read=1, cmd_ack = (remaining>1), cmd_stop = (remaining==1).
    - On rsp: rd_data=rsp_rdata and rd_valid pulses; decrement remaining, increment waddr.
    - When remaining reaches 0 -> DONE.
  - ABORT: issue a STOP-only command (cmd_stop=1, start=0, read=0, wdata=8'hFF), wait for rsp, then -> ERR.
  - DONE / ERR: pulse done or err for one cycle, then -> IDLE.
- Boundaries:
  - waddr wraps 255 -> 0. Crossing from 255 to 0 is also a page boundary.
  - req_len = max gives 2^LEN_W bytes.
  - A host stall on wr_valid stalls the sequencer indefinitely in WDATA, with no timeout.
  - rsp_nack during RDATA is ignored.
  - req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: EEPROM_ACK_POLL_EN.
- Defined: WAIT repeatedly issues a {dev,0} command with start=1 and stop=1 until rsp_nack==0. The WR_WAIT_CYCLES counter is not built.
- Undefined: fixed WR_WAIT_CYCLES wait only.

Decomposition:
- Shared package eeprom_pkg: state encoding, the command-field bundle typedef, and the RW_WRITE/RW_READ constants.
- One natural sub-module: eeprom_wait_timer, a loadable down-counter with a zero flag used by WAIT.

Test Plan:
- Write, dev=7'h50, waddr=8'h10, len=2 (3 bytes AA,BB,CC) -> commands A0(S), 10, AA, BB, CC(P) -> WR_WAIT_CYCLES wait -> done pulse.
- Write, waddr=8'h06, len=3 (4 bytes) -> commands A0(S), 06, d0, d1(P), wait, A0(S), 08, d2, d3(P), wait -> done.
- Read, waddr=8'hFE, len=2 -> commands A0(S), FE, A1(S), then reads with ack=1,1,0 and the last with stop -> rd_valid pulses three times, with internal waddr wrapping to 01 -> done.
- Slave NACK on the DEV_W response -> STOP-only command -> err pulse; no done, no wr_ready.
- Reset asserted during WDATA, after the first data byte -> all outputs 0, req_ready=1 immediately; the next request completes normally.
- EEPROM_ACK_POLL_EN defined, with the bench NACKing 3 polls then ACKing -> 4 poll commands -> done.

Source files
------------

// File: rtl/eeprom_pkg.sv
// Shared types for the EEPROM I2C transaction sequencer: FSM states, the
// byte-command bundle sent to the I2C master and the request direction codes.
package eeprom_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StDevW,
    StWaddr,
    StWdata,
    StWait,
    StDevR,
    StRdata,
    StAbort,
    StDone,
    StErr
  } state_e;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       ack;
    logic [7:0] wdata;
  } cmd_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  function automatic cmd_t mk_cmd(logic start, logic stop, logic read, logic ack,
                                  logic [7:0] wdata);
    cmd_t c;
    c.start = start;
    c.stop  = stop;
    c.read  = read;
    c.ack   = ack;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/eeprom_wait_timer.sv
// Loadable down-counter with a zero flag; times the EEPROM internal write cycle.
module eeprom_wait_timer #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/eeprom_i2c_seq.sv
// Turns host write/random-read requests into I2C byte commands, splitting writes at
// page boundaries. EEPROM_ACK_POLL_EN replaces the fixed write-cycle wait by ACK polling.
module eeprom_i2c_seq
  import eeprom_pkg::*;
#(
  parameter int unsigned LEN_W          = 4,
  parameter int unsigned PAGE_SIZE      = 8,
  parameter int unsigned WR_WAIT_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [6:0]       req_dev,
  input  logic [7:0]       req_waddr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_start,
  output logic             cmd_stop,
  output logic             cmd_read,
  output logic             cmd_ack,
  output logic [7:0]       cmd_wdata,
  input  logic             rsp_valid,
  input  logic [7:0]       rsp_rdata,
  input  logic             rsp_nack
);

  localparam int unsigned REM_W     = LEN_W + 1;
  localparam logic [7:0]  PAGE_MASK = 8'(PAGE_SIZE - 1);

  state_e           state_q, state_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       waddr_q, waddr_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             rw_q, rw_d;
  cmd_t             cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             pend_q, pend_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic       idle_cmd, rsp_fire, page_end, last_byte;
  logic [7:0] waddr_inc;
  state_e     wait_exit;

  assign idle_cmd  = !cmd_valid_q && !pend_q;
  assign rsp_fire  = pend_q && rsp_valid;
  assign waddr_inc = waddr_q + 8'd1;
  assign page_end  = (waddr_inc & PAGE_MASK) == 8'd0;
  assign last_byte = (rem_q == REM_W'(1));
  assign wait_exit = (rem_q == '0) ? StDone : StDevW;

`ifdef EEPROM_ACK_POLL_EN
`else
  localparam int unsigned TMR_W = $clog2(WR_WAIT_CYCLES + 1);
  logic timer_load, timer_zero;

  eeprom_wait_timer #(
    .WIDTH(TMR_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .load_val(TMR_W'(WR_WAIT_CYCLES)),
    .zero    (timer_zero)
  );
`endif

  always_comb begin
    state_d     = state_q;
    dev_d       = dev_q;
    waddr_d     = waddr_q;
    rem_d       = rem_q;
    rw_d        = rw_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    pend_d      = pend_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    wr_ready    = 1'b0;
`ifdef EEPROM_ACK_POLL_EN
`else
    timer_load  = 1'b0;
`endif

    // One command in flight: valid until accepted, then pending until the response.
    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
      pend_d      = 1'b1;
    end
    if (rsp_fire) begin
      pend_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          dev_d   = req_dev;
          waddr_d = req_waddr;
          rem_d   = REM_W'(req_len) + REM_W'(1);
          rw_d    = req_rw;
          state_d = StDevW;
        end
      end
      StDevW: begin
        if (idle_cmd) begin
          cmd_d       = mk_cmd(1'b1, 1'b0, 1'b0, 1'b0, {dev_q, RW_WRITE});
          cmd_valid_d = 1'b1;
        end
        if (rsp_fire) state_d = rsp_nack ? StAbort : StWaddr;
      end
      StWaddr: begin
        if (idle_cmd) begin
          cmd_d       = mk_cmd(1'b0, 1'b0, 1'b0, 1'b0, waddr_q);
          cmd_valid_d = 1'b1;
        end
        if (rsp_fire) begin
          if (rsp_nack)            state_d = StAbort;
          else if (rw_q == RW_READ) state_d = StDevR;
          else                      state_d = StWdata;
        end
      end
      StWdata: begin
        if (idle_cmd && wr_valid) begin
          wr_ready    = 1'b1;
          cmd_d       = mk_cmd(1'b0, last_byte || page_end, 1'b0, 1'b0, wr_data);
          cmd_valid_d = 1'b1;
        end
        if (rsp_fire) begin
          if (rsp_nack) begin
            state_d = StAbort;
          end else begin
            rem_d   = rem_q - REM_W'(1);
            waddr_d = waddr_inc;
            if (cmd_q.stop) begin
              state_d = StWait;
`ifdef EEPROM_ACK_POLL_EN
`else
              timer_load = 1'b1;
`endif
            end
          end
        end
      end
      StWait: begin
`ifdef EEPROM_ACK_POLL_EN
        if (idle_cmd) begin
          cmd_d       = mk_cmd(1'b1, 1'b1, 1'b0, 1'b0, {dev_q, RW_WRITE});
          cmd_valid_d = 1'b1;
        end
        if (rsp_fire && !rsp_nack) state_d = wait_exit;
`else
        if (timer_zero) state_d = wait_exit;
`endif
      end
      StDevR: begin
        if (idle_cmd) begin
          cmd_d       = mk_cmd(1'b1, 1'b0, 1'b0, 1'b0, {dev_q, RW_READ});
          cmd_valid_d = 1'b1;
        end
        if (rsp_fire) state_d = rsp_nack ? StAbort : StRdata;
      end
      StRdata: begin
        if (idle_cmd) begin
          cmd_d       = mk_cmd(1'b0, last_byte, 1'b1, rem_q > REM_W'(1), 8'h00);
          cmd_valid_d = 1'b1;
        end
        // A NACK on a received byte is meaningless, so it is ignored here.
        if (rsp_fire) begin
          rd_data_d  = rsp_rdata;
          rd_valid_d = 1'b1;
          rem_d      = rem_q - REM_W'(1);
          waddr_d    = waddr_inc;
          if (last_byte) state_d = StDone;
        end
      end
      StAbort: begin
        if (idle_cmd) begin
          cmd_d       = mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
          cmd_valid_d = 1'b1;
        end
        if (rsp_fire) state_d = StErr;
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dev_q       <= '0;
      waddr_q     <= '0;
      rem_q       <= '0;
      rw_q        <= RW_WRITE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      pend_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dev_q       <= dev_d;
      waddr_q     <= waddr_d;
      rem_q       <= rem_d;
      rw_q        <= rw_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      pend_q      <= pend_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign done      = (state_q == StDone);
  assign err       = (state_q == StErr);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_start = cmd_q.start;
  assign cmd_stop  = cmd_q.stop;
  assign cmd_read  = cmd_q.read;
  assign cmd_ack   = cmd_q.ack;
  assign cmd_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_eeprom_i2c_seq.sv
// Scoreboard bench for eeprom_i2c_seq: a reference model queues the expected command/read/
// done/err stream per request; a monitor pops and compares; a BFM plays I2C master and host.
module tb_eeprom_i2c_seq;

  localparam int LEN_W      = 4;
  localparam int PAGE       = 8;
  localparam int WAIT       = 40;
  localparam int POLL_NACKS = 3;
  localparam int K_CMD = 0, K_RD = 1, K_DONE = 2, K_ERR = 3;

  logic clk, rst_n;
  logic req_valid, req_ready, req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_waddr;
  logic [LEN_W-1:0] req_len;
  logic [7:0] wr_data, rd_data, cmd_wdata, rsp_rdata;
  logic wr_valid, wr_ready, rd_valid, done, err;
  logic cmd_valid, cmd_ready, cmd_start, cmd_stop, cmd_read, cmd_ack;
  logic rsp_valid, rsp_nack;

  eeprom_i2c_seq #(
    .LEN_W(LEN_W), .PAGE_SIZE(PAGE), .WR_WAIT_CYCLES(WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_dev(req_dev),
    .req_waddr(req_waddr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
    .cmd_stop(cmd_stop), .cmd_read(cmd_read), .cmd_ack(cmd_ack), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack)
  );

  typedef struct {
    int          kind;
    logic [11:0] val;
    bit          pe;
  } ev_t;

  ev_t exp_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] tx_bytes[$];
  int n_checks = 0, n_fail = 0, ends = 0, cyc = 0, last_rsp_cyc = 0;
  int nack_devw = 0, poll_left = POLL_NACKS;
  bit arm = 0;
  logic [7:0] salt;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(int k, logic [11:0] v, bit pe);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.pe   = pe;
    exp_q.push_back(e);
  endtask

  // Reference model: page-split write of tx_bytes starting at waddr.
  task automatic exp_write(logic [6:0] dev, int waddr, int n);
    int a = waddr;
    int i = 0;
    bit last;
    while (i < n) begin
      push(K_CMD, {4'b1000, dev, 1'b0}, 0);
      push(K_CMD, {4'b0000, 8'(a)}, 0);
      last = 0;
      while (!last) begin
        last = (i == n - 1) || ((a + 1) % PAGE == 0);
        push(K_CMD, {1'b0, last, 2'b00, tx_bytes[i]}, last);
        a = (a + 1) % 256;
        i++;
      end
`ifdef EEPROM_ACK_POLL_EN
      repeat (POLL_NACKS + 1) push(K_CMD, {4'b1100, dev, 1'b0}, 0);
`endif
    end
    push(K_DONE, 12'h0, 0);
  endtask

  task automatic exp_read(logic [6:0] dev, int waddr, int n);
    push(K_CMD, {4'b1000, dev, 1'b0}, 0);
    push(K_CMD, {4'b0000, 8'(waddr)}, 0);
    push(K_CMD, {4'b1000, dev, 1'b1}, 0);
    for (int i = 0; i < n; i++) begin
      push(K_CMD, {1'b0, i == n - 1, 1'b1, i < n - 1, 8'h00}, 0);
      push(K_RD, {4'h0, salt ^ 8'((waddr + i) % 256)}, 0);
    end
    push(K_DONE, 12'h0, 0);
  endtask

  task automatic observe(int kind, logic [11:0] val);
    ev_t e;
`ifndef EEPROM_ACK_POLL_EN
    if (arm && (kind == K_CMD || kind == K_DONE)) begin
      chk("write_cycle_wait", 32'((cyc - last_rsp_cyc) >= WAIT), 32'd1);
      arm = 0;
    end
`endif
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d val %0h, required no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_val", 32'(val), 32'(e.val));
      arm = e.pe;
    end
    if (kind == K_DONE || kind == K_ERR) ends++;
  endtask

  // Monitor: one ordered event stream, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cmd_valid && cmd_ready)
          observe(K_CMD, {cmd_start, cmd_stop, cmd_read, cmd_ack, cmd_read ? 8'h00 : cmd_wdata});
        if (rd_valid) observe(K_RD, {4'h0, rd_data});
        if (done) observe(K_DONE, 12'h0);
        if (err) observe(K_ERR, 12'h0);
      end
    end
  end

  // BFM: I2C master (EEPROM behind it) plus host write-data source.
  initial begin
    bit pending = 0, addr_next = 0, hs, wtake, nk;
    int dly = 0;
    logic [7:0] ptr = 8'h00, dat = 8'h00;
    cmd_ready = 0; rsp_valid = 0; rsp_nack = 0; rsp_rdata = 0; wr_valid = 0; wr_data = 0;
    forever begin
      @(negedge clk);
      hs    = cmd_valid && cmd_ready && rst_n;
      wtake = wr_valid && wr_ready;
      if (hs) begin
        pending = 1;
        dly = $urandom_range(0, 3);
        nk = 0;
        if (cmd_start && !cmd_wdata[0]) begin
          if (cmd_stop) begin
            if (poll_left > 0) begin nk = 1; poll_left--; end
            else poll_left = POLL_NACKS;
          end else begin
            if (nack_devw > 0) begin nk = 1; nack_devw--; end
            addr_next = !nk;
          end
        end else if (!cmd_read) begin
          if (addr_next && !cmd_start) begin ptr = cmd_wdata; addr_next = 0; end
        end else begin
          nk = 1'($urandom_range(0, 1));
          dat = salt ^ ptr;
          ptr = ptr + 8'd1;
        end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cmd_ready = 0; rsp_valid = 0; rsp_nack = 0; wr_valid = 0;
        pending = 0; addr_next = 0;
        continue;
      end
      if (wtake && wr_q.size() > 0) void'(wr_q.pop_front());
      wr_valid = (wr_q.size() > 0) && ($urandom_range(0, 3) != 0);
      wr_data  = wr_valid ? wr_q[0] : 8'($urandom);
      rsp_valid = 0;
      rsp_nack  = 0;
      rsp_rdata = 8'($urandom);
      if (pending) begin
        if (dly == 0) begin
          rsp_valid = 1; rsp_nack = nk; rsp_rdata = dat; pending = 0; last_rsp_cyc = cyc;
        end else dly--;
      end
      cmd_ready = !pending && cmd_valid && ($urandom_range(0, 1) == 1);
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!req_ready && t < 1000) begin @(posedge clk); t++; end
    #1;
  endtask

  task automatic issue(bit rw, logic [6:0] dev, logic [7:0] waddr, logic [LEN_W-1:0] len);
    wait_idle();
    @(posedge clk); #1;
    req_valid = 1; req_rw = rw; req_dev = dev; req_waddr = waddr; req_len = len;
    @(posedge clk); #1;
    req_valid = 0; req_rw = $urandom; req_dev = $urandom; req_waddr = $urandom;
  endtask

  task automatic run_req(bit rw, logic [6:0] dev, logic [7:0] waddr, logic [LEN_W-1:0] len,
                         bit nackdev);
    int n = int'(len) + 1;
    int e0 = ends;
    int t = 0;
    if (tx_bytes.size() < n)
      for (int i = tx_bytes.size(); i < n; i++) tx_bytes.push_back(8'($urandom));
    if (nackdev) begin
      nack_devw = 1;
      push(K_CMD, {4'b1000, dev, 1'b0}, 0);
      push(K_CMD, {4'b0100, 8'hFF}, 0);
      push(K_ERR, 12'h0, 0);
    end else if (rw) exp_read(dev, waddr, n);
    else exp_write(dev, waddr, n);
    if (!rw) for (int i = 0; i < n; i++) wr_q.push_back(tx_bytes[i]);
    issue(rw, dev, waddr, len);
    while (ends == e0 && t < 8000) begin @(posedge clk); t++; end
    repeat (2) @(posedge clk);
    #1;
    chk("request_ends_in_time", 32'(ends != e0), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    if (nackdev && !rw) chk("no_wr_ready_after_nack", 32'(wr_q.size()), 32'(n));
    exp_q.delete();
    wr_q.delete();
    tx_bytes.delete();
    arm = 0;
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_cmd"}, {26'd0, cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_ack, wr_ready},
        32'd0);
    chk({tag, "_cmd_wdata"}, 32'(cmd_wdata), 32'd0);
    chk({tag, "_rd"}, {23'd0, rd_valid, rd_data}, 32'd0);
    chk({tag, "_done_err"}, {30'd0, done, err}, 32'd0);
  endtask

  initial begin
    int t;
    rst_n = 0; req_valid = 0; req_rw = 0; req_dev = 0; req_waddr = 0; req_len = 0;
    salt = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1;

    tx_bytes = '{8'hAA, 8'hBB, 8'hCC};
    run_req(0, 7'h50, 8'h10, 4'd2, 0);
    run_req(0, 7'h50, 8'h06, 4'd3, 0);
    run_req(1, 7'h50, 8'hFE, 4'd2, 0);
    run_req(0, 7'h50, 8'h20, 4'd1, 1);
    run_req(0, 7'h51, 8'hF9, 4'd15, 0);
    run_req(1, 7'h52, 8'hF2, 4'd15, 0);
    run_req(1, 7'h53, 8'h40, 4'd0, 0);

    // Reset in WDATA after the first data byte has been taken.
    for (int i = 0; i < 4; i++) tx_bytes.push_back(8'($urandom));
    exp_write(7'h50, 8'h30, 4);
    for (int i = 0; i < 4; i++) wr_q.push_back(tx_bytes[i]);
    issue(0, 7'h50, 8'h30, 4'd3);
    t = 0;
    while (wr_q.size() > 3 && t < 1000) begin @(posedge clk); t++; end
    chk("first_byte_taken", 32'(wr_q.size()), 32'd3);
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #1 check_idle_outputs("mid_reset");
    exp_q.delete(); wr_q.delete(); tx_bytes.delete();
    arm = 0; nack_devw = 0; poll_left = POLL_NACKS;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run_req(0, 7'h50, 8'h30, 4'd3, 0);

    for (int k = 0; k < 10; k++)
      run_req(1'($urandom), 7'($urandom), 8'($urandom), 4'($urandom), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
